// File: rtl/led_sequencer.sv
// Commanded LED pattern sequencer: OFF / 3-bit binary count / one-hot chase / PWM breathe.
// A prescaler and per-command rate divider schedule pattern steps; accepts restart the pattern.
module led_sequencer #(
    parameter int PRESCALE = 20800,
    parameter int PWM_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_rate,
    output logic [2:0] led_out,
    output logic       step_tick,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    localparam logic [1:0]       MODE_OFF     = 2'd0;
    localparam logic [1:0]       MODE_BINARY  = 2'd1;
    localparam logic [1:0]       MODE_CHASE   = 2'd2;
    localparam logic [1:0]       MODE_BREATHE = 2'd3;
    localparam logic [15:0]      PRESC_LAST   = 16'(PRESCALE - 1);
    localparam logic [PWM_W-1:0] DUTY_ONE     = PWM_W'(1);
    localparam logic [PWM_W-1:0] DUTY_MAX     = '1;
    localparam logic [PWM_W-1:0] DUTY_TURN    = DUTY_MAX - DUTY_ONE;

    state_t           state_reg, state_next;
    logic [1:0]       mode_reg, mode_next;
    logic [7:0]       rate_reg, rate_next;
    logic [15:0]      presc_reg, presc_next;
    logic [7:0]       rate_cnt_reg, rate_cnt_next;
    logic [2:0]       pattern_reg, pattern_next;
    logic [PWM_W-1:0] duty_reg, duty_next;
    logic             dir_up_reg, dir_up_next;
    logic [PWM_W-1:0] pwm_cnt_reg, pwm_cnt_next;
    logic [2:0]       led_reg, led_next;
    logic             step_tick_reg, step_tick_next;
    logic             busy_reg, busy_next;

    logic       accept;
    logic       base_tick;
    logic       step;
    logic       pwm_on;
    logic [2:0] pwm_led;

    assign cmd_ready = (state_reg != LOAD);
    assign accept    = cmd_valid && cmd_ready;
    assign base_tick = (state_reg == RUN) && (presc_reg == PRESC_LAST);
    assign step      = base_tick && (rate_cnt_reg == rate_reg);
    assign pwm_on    = (pwm_cnt_reg < duty_reg);

    for (genvar gi = 0; gi < 3; gi++) begin : g_pwm_led
        assign pwm_led[gi] = pwm_on;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_OFF;
            rate_reg      <= '0;
            presc_reg     <= '0;
            rate_cnt_reg  <= '0;
            pattern_reg   <= '0;
            duty_reg      <= '0;
            dir_up_reg    <= 1'b1;
            pwm_cnt_reg   <= '0;
            led_reg       <= '0;
            step_tick_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            rate_reg      <= rate_next;
            presc_reg     <= presc_next;
            rate_cnt_reg  <= rate_cnt_next;
            pattern_reg   <= pattern_next;
            duty_reg      <= duty_next;
            dir_up_reg    <= dir_up_next;
            pwm_cnt_reg   <= pwm_cnt_next;
            led_reg       <= led_next;
            step_tick_reg <= step_tick_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mode_next      = mode_reg;
        rate_next      = rate_reg;
        presc_next     = presc_reg;
        rate_cnt_next  = rate_cnt_reg;
        pattern_next   = pattern_reg;
        duty_next      = duty_reg;
        dir_up_next    = dir_up_reg;
        pwm_cnt_next   = pwm_cnt_reg;
        led_next       = led_reg;
        step_tick_next = 1'b0;
        busy_next      = busy_reg;

        case (state_reg)
            IDLE: begin
                led_next  = '0;
                busy_next = 1'b0;
                if (accept) begin
                    mode_next  = cmd_mode;
                    rate_next  = cmd_rate;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                presc_next    = '0;
                rate_cnt_next = '0;
                pwm_cnt_next  = '0;
                pattern_next  = (mode_reg == MODE_CHASE) ? 3'b001 : 3'b000;
                duty_next     = '0;
                dir_up_next   = 1'b1;
                state_next    = (mode_reg == MODE_OFF) ? IDLE : RUN;
            end
            RUN: begin
                busy_next = 1'b1;
                // A new command wins over a coincident step: outputs hold until LOAD reinitialises.
                if (accept) begin
                    mode_next  = cmd_mode;
                    rate_next  = cmd_rate;
                    state_next = LOAD;
                end else begin
                    presc_next     = base_tick ? 16'd0 : presc_reg + 16'd1;
                    pwm_cnt_next   = pwm_cnt_reg + DUTY_ONE;
                    step_tick_next = step;
                    if (base_tick) begin
                        rate_cnt_next = step ? 8'd0 : rate_cnt_reg + 8'd1;
                    end
                    case (mode_reg)
                        MODE_BINARY: begin
                            if (step) begin
                                pattern_next = pattern_reg + 3'd1;
                            end
                            led_next = pattern_next;
                        end
                        MODE_CHASE: begin
                            if (step) begin
                                pattern_next = {pattern_reg[1:0], pattern_reg[2]};
                            end
                            led_next = pattern_next;
                        end
                        MODE_BREATHE: begin
                            // Duty ramps as a triangle and turns around at the rails without wrapping.
                            if (step) begin
                                if (dir_up_reg) begin
                                    duty_next = duty_reg + DUTY_ONE;
                                    if (duty_reg == DUTY_TURN) begin
                                        dir_up_next = 1'b0;
                                    end
                                end else begin
                                    duty_next = duty_reg - DUTY_ONE;
                                    if (duty_reg == DUTY_ONE) begin
                                        dir_up_next = 1'b1;
                                    end
                                end
                            end
                            led_next = pwm_led;
                        end
                        default: led_next = '0;
                    endcase
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign led_out   = led_reg;
    assign step_tick = step_tick_reg;
    assign busy      = busy_reg;

endmodule
